mux_sel_sequencer: RTL and testbench

//  Upstream control stage for the 4:1 select mux. Scans four request lines round-robin and drives s1/s0.

---
 rtl/mux_seq_pkg.sv | 6 +
 rtl/mux_sel_sequencer_rr_pick.sv | 16 +
 rtl/mux_sel_sequencer.sv | 105 ++++++++++
 tb/tb_mux_sel_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mux_seq_pkg.sv
// mux_seq_pkg: shared types for the mux select sequencer
package mux_seq_pkg;
    localparam int NUM_CH = 4;
    typedef logic [1:0] chan_t;
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
endpackage

// File: rtl/mux_sel_sequencer_rr_pick.sv
// rr_pick: round-robin first-one search starting just after the last granted channel
module rr_pick import mux_seq_pkg::*; (
    input  logic [NUM_CH-1:0] req,
    input  chan_t             last,
    output logic              any,
    output chan_t             grant
);
    always_comb begin
        any   = |req;
        grant = last;
        // scan from lowest to highest priority so the highest-priority hit is written last
        for (int i = NUM_CH; i >= 1; i--) begin
            if (req[last + chan_t'(i)]) grant = last + chan_t'(i);
        end
    end
endmodule

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: round-robin 4:1 mux select driver that settles, captures y and offers {chan,data}
// Optional HOLD timeout with drop pulse when MUX_SEQ_TIMEOUT_EN is defined.
module mux_sel_sequencer import mux_seq_pkg::*; #(
    parameter int SETTLE_CYCLES = 2
`ifdef MUX_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 8
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              y,
    output logic              s1,
    output logic              s0,
    output logic              out_valid,
    input  logic              out_ready,
    output chan_t             out_chan,
    output logic              out_data
`ifdef MUX_SEQ_TIMEOUT_EN
    ,
    output logic              drop
`endif
);
    state_t     r_state, w_next;
    chan_t      r_sel, r_last, r_chan, w_grant;
    logic [3:0] r_cnt;
    logic       r_valid, r_data;
    logic       w_any, w_accept, w_timeout, w_done;

    rr_pick u_pick (.req(req), .last(r_last), .any(w_any), .grant(w_grant));

    assign {s1, s0}  = r_sel;
    assign out_valid = r_valid;
    assign out_chan  = r_chan;
    assign out_data  = r_data;
    assign w_accept  = r_valid && out_ready;
`ifdef MUX_SEQ_TIMEOUT_EN
    logic [7:0] r_tcnt;
    logic       r_drop;
    assign drop      = r_drop;
    assign w_timeout = !out_ready && r_tcnt == 8'(TIMEOUT - 1);
`else
    assign w_timeout = 1'b0;
`endif
    assign w_done    = w_accept || w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_any ? SETTLE : IDLE;
            SETTLE:  w_next = r_cnt == '0 ? HOLD : SETTLE;
            HOLD:    w_next = w_done ? IDLE : HOLD;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel   <= '0;
            r_last  <= 2'd3;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_chan  <= '0;
            r_data  <= 1'b0;
`ifdef MUX_SEQ_TIMEOUT_EN
            r_tcnt  <= '0;
            r_drop  <= 1'b0;
`endif
        end else begin
`ifdef MUX_SEQ_TIMEOUT_EN
            r_drop <= 1'b0;
`endif
            case (r_state)
                IDLE: if (w_any) begin
                    r_sel <= w_grant;
                    r_cnt <= 4'(SETTLE_CYCLES - 1);
                end
                SETTLE: if (r_cnt == '0) begin
                    r_valid <= 1'b1;
                    r_chan  <= r_sel;
                    r_data  <= y;
`ifdef MUX_SEQ_TIMEOUT_EN
                    r_tcnt  <= '0;
`endif
                end else r_cnt <= r_cnt - 4'd1;
                HOLD: if (w_done) begin
                    r_valid <= 1'b0;
                    r_last  <= r_chan;
`ifdef MUX_SEQ_TIMEOUT_EN
                    r_drop  <= w_timeout;
                end else if (!out_ready) begin
                    r_tcnt  <= r_tcnt + 8'd1;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb_mux_sel_sequencer: scoreboard bench with a 4:1 mux model (i0..i3 = 1,0,1,0)
module tb_mux_sel_sequencer;
    logic       clk = 1'b0, rst = 1'b1, out_ready = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       y, s1, s0, out_valid, out_data;
    logic [1:0] out_chan;
`ifdef MUX_SEQ_TIMEOUT_EN
    logic       drop;
`endif
    logic [3:0] i_vec = 4'b0101;
    logic [1:0] m_last = 2'd3;
    logic [2:0] exp_q[$];
    logic [2:0] e;
    int         total = 0, bad = 0;

    mux_sel_sequencer dut (
        .clk(clk), .rst(rst), .req(req), .y(y), .s1(s1), .s0(s0),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan), .out_data(out_data)
`ifdef MUX_SEQ_TIMEOUT_EN
        , .drop(drop)
`endif
    );

    always #5 clk = ~clk;
    assign y = i_vec[{s1, s0}];

    function automatic logic [1:0] model_pick(logic [3:0] r, logic [1:0] l);
        for (int k = 1; k <= 4; k++) if (r[(int'(l) + k) % 4]) return 2'((int'(l) + k) % 4);
        return l;
    endfunction

    task automatic push_grant(input logic [3:0] r);
        logic [1:0] c;
        c = model_pick(r, m_last);
        exp_q.push_back({c, i_vec[c]});
        m_last = c;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0; m_last = 2'd3; exp_q.delete();
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if ({s1, s0} !== 2'b00) begin bad++; $display("FAIL reset_sel got=%b want=00", {s1, s0}); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if ({out_chan, out_data} !== 3'b000) begin bad++; $display("FAIL reset_sample got=%b want=000", {out_chan, out_data}); end
`ifdef MUX_SEQ_TIMEOUT_EN
        total++; if (drop !== 1'b0) begin bad++; $display("FAIL reset_drop got=%b want=0", drop); end
`endif
    endtask

    task automatic test_single();
        int n;
        do_reset();
        req = 4'b0001; out_ready = 1'b1; push_grant(req);
        @(negedge clk);
        total++; if ({s1, s0, out_valid} !== 3'b000) begin bad++; $display("FAIL t1_select got=%b want=000", {s1, s0, out_valid}); end
        req = '0;
        wait_valid(n);
        total++; if (n !== 2) begin bad++; $display("FAIL t1_latency got=%0d want=2", n); end
        e = exp_q.pop_front();
        total++; if ({out_chan, out_data} !== e) begin bad++; $display("FAIL t1_sample got=%b want=%b", {out_chan, out_data}, e); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t1_accept got=%b want=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        req = 4'b1111; out_ready = 1'b1;
        repeat (5) push_grant(4'b1111);
        for (int i = 0; i < 5; i++) begin
            wait_valid(n);
            if (i == 4) req = '0;
            e = exp_q.pop_front();
            total++; if (!out_valid || {out_chan, out_data} !== e) begin bad++; $display("FAIL t2_sample%0d got=%b/%b want=1/%b", i, out_valid, {out_chan, out_data}, e); end
            total++; if (n !== (i == 0 ? 3 : 4)) begin bad++; $display("FAIL t2_gap%0d got=%0d want=%0d", i, n, i == 0 ? 3 : 4); end
        end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t2_end got=%b want=0", out_valid); end
    endtask

    task automatic test_stall();
        int n, extra;
        do_reset();
        req = 4'b0100; out_ready = 1'b0; push_grant(req);
        wait_valid(n);
        req = '0;
        e = exp_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            total++; if ({out_valid, out_chan, out_data} !== {1'b1, e}) begin bad++; $display("FAIL t3_stable%0d got=%b want=1%b", k, {out_valid, out_chan, out_data}, e); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t3_accept got=%b want=0", out_valid); end
        extra = 0;
        repeat (6) begin @(negedge clk); if (out_valid) extra++; end
        total++; if (extra !== 0) begin bad++; $display("FAIL t3_dup got=%0d want=0", extra); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        req = 4'b1000; out_ready = 1'b1;
        @(negedge clk);
        total++; if ({s1, s0} !== 2'b11) begin bad++; $display("FAIL t4_select got=%b want=11", {s1, s0}); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if ({s1, s0, out_valid} !== 3'b000) begin bad++; $display("FAIL t4_async got=%b want=000", {s1, s0, out_valid}); end
        @(negedge clk);
        rst = 1'b0; m_last = 2'd3; exp_q.delete(); push_grant(req);
        wait_valid(n);
        req = '0;
        e = exp_q.pop_front();
        total++; if (!out_valid || {out_chan, out_data} !== e || n !== 3) begin bad++; $display("FAIL t4_regrant got=%b/%b n=%0d want=1/%b n=3", out_valid, {out_chan, out_data}, n, e); end
        @(negedge clk);
    endtask

    task automatic test_pulse();
        int n;
        do_reset();
        req = 4'b0010; out_ready = 1'b1; push_grant(req);
        @(negedge clk);
        req = '0;
        wait_valid(n);
        e = exp_q.pop_front();
        total++; if (!out_valid || {out_chan, out_data} !== e) begin bad++; $display("FAIL t5_sample got=%b/%b want=1/%b", out_valid, {out_chan, out_data}, e); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL t5_accept got=%b want=0", out_valid); end
    endtask

`ifdef MUX_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int n, early;
        do_reset();
        req = 4'b1111; out_ready = 1'b0; push_grant(req);
        wait_valid(n);
        e = exp_q.pop_front();
        total++; if (!out_valid || {out_chan, out_data} !== e) begin bad++; $display("FAIL t6_first got=%b/%b want=1/%b", out_valid, {out_chan, out_data}, e); end
        early = 0;
        repeat (7) begin @(negedge clk); if (!out_valid || drop) early++; end
        total++; if (early !== 0) begin bad++; $display("FAIL t6_early got=%0d want=0", early); end
        @(negedge clk);
        total++; if ({out_valid, drop} !== 2'b01) begin bad++; $display("FAIL t6_drop got=%b want=01", {out_valid, drop}); end
        push_grant(req);
        @(negedge clk);
        total++; if (drop !== 1'b0) begin bad++; $display("FAIL t6_pulse got=%b want=0", drop); end
        wait_valid(n);
        req = '0; out_ready = 1'b1;
        e = exp_q.pop_front();
        total++; if (!out_valid || {out_chan, out_data} !== e) begin bad++; $display("FAIL t6_next got=%b/%b want=1/%b", out_valid, {out_chan, out_data}, e); end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_pulse();
`ifdef MUX_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
